// File: rtl/fnf_exerciser.sv
// Stimulus generator and response checker for the registered-NAND tutorial block.
// Applies a counter or LFSR vector sequence and checks the NAND response LATENCY cycles later.
module fnf_exerciser #(
    parameter int NUM_VECTORS = 16,
    parameter int LATENCY     = 2,
    parameter int PATTERN     = 0,
    parameter int ERR_W       = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             OutputPad,
    output logic             Input1,
    output logic             Input2,
    output logic             Busy,
    output logic             Done,
    output logic             Pass,
    output logic [ERR_W-1:0] ErrorCount,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS);
    localparam logic [3:0]  LAT_M1   = 4'(LATENCY - 1);
    localparam logic [7:0]  SEED     = 8'h01;

    state_t             state, next_state;
    logic [15:0]        idx;
    logic [7:0]         lfsr;
    logic [3:0]         flush_cnt;
    logic               vec_valid;
    logic               err_flag;
    logic [LATENCY-1:0] pipe_v;
    logic [LATENCY-1:0] pipe_e;

    logic               start_run, advance, apply, mismatch;
    logic [15:0]        cur_idx;
    logic [7:0]         cur_lfsr;
    logic [1:0]         vec;

    // Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    always_comb begin
        next_state = state;
        start_run  = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: if (Start) begin
                next_state = RUN;
                start_run  = 1'b1;
            end
            RUN: if (idx == LAST_IDX) next_state = FLUSH;
                 else advance = 1'b1;
            FLUSH: if (flush_cnt == LAT_M1) next_state = DONE;
            DONE: if (Start) begin
                next_state = RUN;
                start_run  = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // A new run restarts the sources from index 0 / seed on the accepting edge.
    always_comb begin
        apply    = start_run | advance;
        cur_idx  = start_run ? 16'd0 : idx;
        cur_lfsr = start_run ? SEED : lfsr;
        vec      = (PATTERN == 1) ? cur_lfsr[1:0] : cur_idx[1:0];
        mismatch = pipe_v[LATENCY-1] && (pipe_e[LATENCY-1] != OutputPad);
        Busy     = (state == RUN) || (state == FLUSH);
        Done     = (state == DONE);
        fsm_state = state;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            idx       <= '0;
            lfsr      <= SEED;
            flush_cnt <= '0;
            Input1    <= 1'b0;
            Input2    <= 1'b0;
            vec_valid <= 1'b0;
        end else begin
            state     <= next_state;
            flush_cnt <= (state == FLUSH) ? flush_cnt + 4'd1 : 4'd0;
            if (apply) begin
                Input1    <= vec[1];
                Input2    <= vec[0];
                vec_valid <= 1'b1;
                idx       <= cur_idx + 16'd1;
                lfsr      <= lfsr_next(cur_lfsr);
            end else begin
                Input1    <= 1'b0;
                Input2    <= 1'b0;
                vec_valid <= 1'b0;
            end
        end
    end

    // Expected-response pipeline, aligned so stage LATENCY-1 meets the matching OutputPad.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pipe_v <= '0;
            pipe_e <= '0;
        end else begin
            pipe_v[0] <= vec_valid;
            pipe_e[0] <= ~(Input1 & Input2);
            for (int i = 1; i < LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_e[i] <= pipe_e[i-1];
            end
        end
    end

    // err_flag is kept apart from ErrorCount so Pass is still right after saturation.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ErrorCount <= '0;
            err_flag   <= 1'b0;
            Pass       <= 1'b0;
        end else if (start_run) begin
            ErrorCount <= '0;
            err_flag   <= 1'b0;
            Pass       <= 1'b0;
        end else begin
            if (mismatch) begin
                err_flag <= 1'b1;
                if (!(&ErrorCount)) ErrorCount <= ErrorCount + 1'b1;
            end
            if (state == FLUSH && next_state == DONE) Pass <= !(err_flag || mismatch);
        end
    end

endmodule
